// File: rtl/change_dispenser.sv
// Change dispenser: ejects the vended item, then coins largest-first, one
// valid/ready handshake per ejection followed by a fixed solenoid recovery gap.
module change_dispenser #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       dispense_item,
    input  logic [2:0] item_dispensed,
    input  logic [4:0] change_nickels,
    input  logic [3:0] change_dimes,
    input  logic [1:0] change_quarters,
    input  logic       change_dollar,
    output logic       item_valid,
    output logic [2:0] item_code,
    input  logic       item_ready,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    input  logic       coin_ready,
    output logic       busy,
    output logic       done,
    output logic [8:0] value_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITEM,
        S_SEL,
        S_COIN,
        S_GAP,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_DOLLAR  = 2'b11
    } coin_e;

    // The gap counter is loaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LOAD   = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_e     AFTER_EJECT = (GAP_CYCLES == 0) ? S_SEL : S_GAP;

    state_e     state_q, state_d;
    logic [2:0] item_code_q, item_code_d;
    logic [4:0] nickels_q, nickels_d;
    logic [3:0] dimes_q, dimes_d;
    logic [1:0] quarters_q, quarters_d;
    logic       dollar_q, dollar_d;
    coin_e      coin_type_q, coin_type_d;
    logic [8:0] value_q, value_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            item_code_q <= '0;
            nickels_q   <= '0;
            dimes_q     <= '0;
            quarters_q  <= '0;
            dollar_q    <= 1'b0;
            coin_type_q <= COIN_NICKEL;
            value_q     <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            item_code_q <= item_code_d;
            nickels_q   <= nickels_d;
            dimes_q     <= dimes_d;
            quarters_q  <= quarters_d;
            dollar_q    <= dollar_d;
            coin_type_q <= coin_type_d;
            value_q     <= value_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its register first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        item_code_d = item_code_q;
        nickels_d   = nickels_q;
        dimes_d     = dimes_q;
        quarters_d  = quarters_q;
        dollar_d    = dollar_q;
        coin_type_d = coin_type_q;
        value_d     = value_q;
        gap_cnt_d   = gap_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    item_code_d = item_dispensed;
                    nickels_d   = change_nickels;
                    dimes_d     = change_dimes;
                    quarters_d  = change_quarters;
                    dollar_d    = change_dollar;
                    value_d     = '0;
                    state_d     = dispense_item ? S_ITEM : S_SEL;
                end
            end
            S_ITEM: begin
                if (item_ready) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = AFTER_EJECT;
                end
            end
            S_SEL: begin
                state_d = S_COIN;
                if (dollar_q) begin
                    coin_type_d = COIN_DOLLAR;
                end else if (quarters_q != '0) begin
                    coin_type_d = COIN_QUARTER;
                end else if (dimes_q != '0) begin
                    coin_type_d = COIN_DIME;
                end else if (nickels_q != '0) begin
                    coin_type_d = COIN_NICKEL;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_COIN: begin
                if (coin_ready) begin
                    unique case (coin_type_q)
                        COIN_DOLLAR: begin
                            dollar_d = 1'b0;
                            value_d  = value_q + 9'd100;
                        end
                        COIN_QUARTER: begin
                            quarters_d = quarters_q - 2'd1;
                            value_d    = value_q + 9'd25;
                        end
                        COIN_DIME: begin
                            dimes_d = dimes_q - 4'd1;
                            value_d = value_q + 9'd10;
                        end
                        COIN_NICKEL: begin
                            nickels_d = nickels_q - 5'd1;
                            value_d   = value_q + 9'd5;
                        end
                    endcase
                    gap_cnt_d = GAP_LOAD;
                    state_d   = AFTER_EJECT;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_SEL;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valids decode the registered state only, never the ready inputs.
    assign item_valid = (state_q == S_ITEM);
    assign coin_valid = (state_q == S_COIN);
    assign item_code  = item_code_q;
    assign coin_type  = coin_type_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign value_out  = value_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed and randomized transactions
// compared against an ejection-order and cents model built from the counts.
module tb_change_dispenser;

    localparam int GAP = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       dispense_item;
    logic [2:0] item_dispensed;
    logic [4:0] change_nickels;
    logic [3:0] change_dimes;
    logic [1:0] change_quarters;
    logic       change_dollar;
    logic       item_valid;
    logic [2:0] item_code;
    logic       item_ready;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ready;
    logic       busy;
    logic       done;
    logic [8:0] value_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    change_dispenser #(.GAP_CYCLES(GAP)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .dispense_item   (dispense_item),
        .item_dispensed  (item_dispensed),
        .change_nickels  (change_nickels),
        .change_dimes    (change_dimes),
        .change_quarters (change_quarters),
        .change_dollar   (change_dollar),
        .item_valid      (item_valid),
        .item_code       (item_code),
        .item_ready      (item_ready),
        .coin_valid      (coin_valid),
        .coin_type       (coin_type),
        .coin_ready      (coin_ready),
        .busy            (busy),
        .done            (done),
        .value_out       (value_out)
    );

    function automatic int coin_cents(input int t);
        case (t)
            3: return 100;
            2: return 25;
            1: return 10;
            default: return 5;
        endcase
    endfunction

    // Ejection events: 16+slot for the item, 0..3 for a coin type.
    // ready_mode 0 = readies tied high, 1 = random readies.
    task automatic run_txn(input string name, input logic di, input logic [2:0] code,
                           input int n, input int d, input int q, input int dol,
                           input int ready_mode, input int hold_q, input bit spam,
                           input int exp_done_lat);
        int exp_q[$];
        int got_q[$];
        int exp_val;
        int run_val;
        int done_cnt;
        int done_cyc;
        int last_acc;
        int hold_left;
        bit pend;
        bit pend_item;
        logic [2:0] pend_code;
        logic [1:0] pend_type;
        bit seen_done;
        bit finished;

        if (di) exp_q.push_back(16 + int'(code));
        for (int i = 0; i < dol; i++) exp_q.push_back(3);
        for (int i = 0; i < q; i++) exp_q.push_back(2);
        for (int i = 0; i < d; i++) exp_q.push_back(1);
        for (int i = 0; i < n; i++) exp_q.push_back(0);
        exp_val = dol * 100 + q * 25 + d * 10 + n * 5;

        run_val = 0; done_cnt = 0; done_cyc = -1; last_acc = -1;
        hold_left = hold_q; pend = 0; pend_item = 0; pend_code = '0; pend_type = '0;
        seen_done = 0; finished = 0;

        @(negedge clock);
        start           = 1'b1;
        dispense_item   = di;
        item_dispensed  = code;
        change_nickels  = 5'(n);
        change_dimes    = 4'(d);
        change_quarters = 2'(q);
        change_dollar   = 1'(dol);

        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (seen_done) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || item_valid !== 1'b0 || coin_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_after_done: busy=%b done=%b iv=%b cv=%b, required all 0",
                             name, busy, done, item_valid, coin_valid);
                end
                finished = 1;
                continue;
            end
            if (cyc == 1 && !done) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_rise: busy=%b required 1", name, busy);
                end
            end
            checks++;
            if (value_out !== 9'(run_val)) begin
                errors++;
                $display("FAIL %s value_running cyc %0d: got %0d required %0d", name, cyc, value_out, run_val);
            end
            if (item_valid === 1'b1 && coin_valid === 1'b1) begin
                errors++;
                $display("FAIL %s two_valids cyc %0d: both item_valid and coin_valid high", name, cyc);
            end
            if (pend) begin
                checks++;
                if (pend_item ? (item_valid !== 1'b1 || item_code !== pend_code)
                              : (coin_valid !== 1'b1 || coin_type !== pend_type)) begin
                    errors++;
                    $display("FAIL %s hold_stable cyc %0d: iv=%b code=%0d cv=%b type=%0d, required held %s code=%0d type=%0d",
                             name, cyc, item_valid, item_code, coin_valid, coin_type,
                             pend_item ? "item" : "coin", pend_code, pend_type);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc  = cyc;
                seen_done = 1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_in_done: busy=%b required 0", name, busy);
                end
                if (spam) begin
                    start           = 1'b1;
                    dispense_item   = 1'b1;
                    item_dispensed  = 3'($urandom);
                    change_nickels  = 5'($urandom);
                    change_dimes    = 4'($urandom);
                    change_quarters = 2'($urandom);
                    change_dollar   = 1'b1;
                end
            end else if (spam && (cyc == 3 || cyc == 7)) begin
                start           = 1'b1;
                dispense_item   = 1'b1;
                item_dispensed  = 3'($urandom);
                change_nickels  = 5'($urandom);
                change_dimes    = 4'($urandom);
                change_quarters = 2'($urandom);
                change_dollar   = 1'b1;
            end

            item_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            coin_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (coin_valid === 1'b1 && coin_type == 2'b10 && hold_left > 0) begin
                coin_ready = 1'b0;
                hold_left--;
            end

            pend = 0;
            if (item_valid === 1'b1) begin
                if (item_ready) begin
                    got_q.push_back(16 + int'(item_code));
                    if (ready_mode == 0 && last_acc >= 0) begin
                        checks++;
                        if (cyc - last_acc != 2 + GAP) begin
                            errors++;
                            $display("FAIL %s spacing: got %0d cycles required %0d", name, cyc - last_acc, 2 + GAP);
                        end
                    end
                    last_acc = cyc;
                end else begin
                    pend = 1; pend_item = 1; pend_code = item_code;
                end
            end
            if (coin_valid === 1'b1) begin
                if (coin_ready) begin
                    got_q.push_back(int'(coin_type));
                    run_val += coin_cents(int'(coin_type));
                    if (ready_mode == 0 && hold_q == 0 && last_acc >= 0) begin
                        checks++;
                        if (cyc - last_acc != 2 + GAP) begin
                            errors++;
                            $display("FAIL %s spacing: got %0d cycles required %0d", name, cyc - last_acc, 2 + GAP);
                        end
                    end
                    last_acc = cyc;
                end else begin
                    pend = 1; pend_item = 0; pend_type = coin_type;
                end
            end
        end
        item_ready = 1'b0;
        coin_ready = 1'b0;
        start      = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: transaction did not complete within 3000 cycles", name);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s eject_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL %s eject_order[%0d]: got %0d required %0d", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (value_out !== 9'(exp_val)) begin
            errors++;
            $display("FAIL %s value_final: got %0d required %0d", name, value_out, exp_val);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
        if (exp_done_lat >= 0) begin
            checks++;
            if (done_cyc != exp_done_lat) begin
                errors++;
                $display("FAIL %s done_latency: got %0d required %0d", name, done_cyc, exp_done_lat);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; dispense_item = 1'b0; item_dispensed = '0;
        change_nickels = '0; change_dimes = '0; change_quarters = '0; change_dollar = 1'b0;
        item_ready = 1'b0; coin_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({item_valid, coin_valid, busy, done, item_code, coin_type, value_out} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: iv=%b cv=%b busy=%b done=%b code=%0d type=%0d value=%0d required all 0",
                     item_valid, coin_valid, busy, done, item_code, coin_type, value_out);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_coin();
        bit accepted = 0;
        bit ready_for_reset = 0;
        @(negedge clock);
        start = 1'b1; dispense_item = 1'b0; item_dispensed = 3'd6;
        change_nickels = 5'd0; change_dimes = 4'd0; change_quarters = 2'd2; change_dollar = 1'b0;
        for (int i = 0; i < 40 && !ready_for_reset; i++) begin
            @(negedge clock);
            start = 1'b0;
            coin_ready = 1'b0;
            if (coin_valid === 1'b1) begin
                if (!accepted) begin
                    coin_ready = 1'b1;
                    accepted = 1;
                end else if (value_out === 9'd25) begin
                    ready_for_reset = 1;
                end
            end
        end
        checks++;
        if (!ready_for_reset) begin
            errors++;
            $display("FAIL reset_mid_coin setup: second coin_valid not reached in 40 cycles");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({item_valid, coin_valid, busy, done, item_code, coin_type, value_out} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_coin: iv=%b cv=%b busy=%b done=%b code=%0d type=%0d value=%0d required all 0",
                     item_valid, coin_valid, busy, done, item_code, coin_type, value_out);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_coin no_resume: busy=%b cv=%b required 0 0", busy, coin_valid);
        end
        run_txn("after_reset", 1'b0, 3'd0, 2, 1, 0, 0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_item_sequence();
        run_txn("item_seq", 1'b1, 3'd5, 1, 0, 1, 1, 0, 0, 1'b0, -1);
    endtask

    task automatic test_quarter_hold();
        run_txn("quarter_hold", 1'b1, 3'd5, 1, 0, 1, 1, 0, 7, 1'b0, -1);
    endtask

    task automatic test_full_load();
        run_txn("full_load", 1'b0, 3'd0, 31, 15, 3, 1, 0, 0, 1'b0, -1);
    endtask

    task automatic test_zero();
        run_txn("zero", 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0, 2);
    endtask

    task automatic test_start_ignored();
        run_txn("start_ignored", 1'b1, 3'd2, 3, 2, 1, 0, 0, 0, 1'b1, -1);
        run_txn("start_ignored_zero", 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 1'b1, 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            run_txn($sformatf("random%0d", t), 1'($urandom_range(0, 1)), 3'($urandom),
                    $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 1), 1, 0, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_item_sequence();
        test_quarter_hold();
        test_full_load();
        test_zero();
        test_start_ignored();
        test_reset_mid_coin();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
